// File: rtl/jamma_joy_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : jamma_joy_scanner
//  Description : Time-multiplexed JAMMA player-bus scanner with per-bit
//                debounce. A scan alternates JSELECT between player 1 and
//                player 2, samples the shared bus once per player after a
//                settle delay, then commits all 18 raw bits to the debouncers.
//
//  Ports
//    pclk       in   1  clock, rising edge
//    reset      in   1  synchronous active-high reset
//    JJOY       in   8  shared player bus, active-low ([5:0] dirs/buttons, [7] start)
//    JOYSTICK   in   6  local DB9 joystick, active-low, merged into player 1
//    JCOIN      in   2  coin switches, active-low
//    JSELECT    out  1  bus mux select (0 = player 1, 1 = player 2)
//    joystick1  out  8  debounced player-1 state, active-low
//    joystick2  out  8  debounced player-2 state, active-low
//    coin       out  2  debounced coin state, active-low
//    scan_done  out  1  one-cycle pulse during the commit cycle
//
//  Revision    : 1.0  initial release
// ============================================================================
module jamma_joy_scanner #(
    parameter int SETTLE_CYCLES = 8,   // 1..255
    parameter int DEBOUNCE      = 3    // 1..15
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] JJOY,
    input  logic [5:0] JOYSTICK,
    input  logic [1:0] JCOIN,
    output logic       JSELECT,
    output logic [7:0] joystick1,
    output logic [7:0] joystick2,
    output logic [1:0] coin,
    output logic       scan_done
);

    localparam logic [2:0] c_SETTLE1 = 3'd0;
    localparam logic [2:0] c_SAMPLE1 = 3'd1;
    localparam logic [2:0] c_SETTLE2 = 3'd2;
    localparam logic [2:0] c_SAMPLE2 = 3'd3;
    localparam logic [2:0] c_COMMIT  = 3'd4;

    localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] c_DEBOUNCE    = 4'(DEBOUNCE);
    localparam int         c_NBITS       = 18;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [7:0]         r_settle_cnt;
    logic               w_settle_last;
    logic               w_in_settle;
    logic               r_jselect;
    logic               r_scan_done;
    logic [7:0]         r_raw1;
    logic [7:0]         r_raw2;
    logic [1:0]         r_rawc;
    logic [c_NBITS-1:0] w_raw_all;
    logic [c_NBITS-1:0] w_db_out;

    assign w_in_settle   = (r_state == c_SETTLE1) || (r_state == c_SETTLE2);
    assign w_settle_last = (r_settle_cnt == c_SETTLE_LAST);

    // ------------------------------------------------------------------
    // Scan sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state <= c_SETTLE1;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_SETTLE1: if (w_settle_last) w_next_state = c_SAMPLE1;
            c_SAMPLE1: w_next_state = c_SETTLE2;
            c_SETTLE2: if (w_settle_last) w_next_state = c_SAMPLE2;
            c_SAMPLE2: w_next_state = c_COMMIT;
            c_COMMIT:  w_next_state = c_SETTLE1;
            default:   w_next_state = c_SETTLE1;
        endcase
    end

    // Settle counter runs only inside a settle state and is zero on entry,
    // so each settle state lasts exactly SETTLE_CYCLES cycles.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_settle_cnt <= '0;
        end else if (w_in_settle && !w_settle_last) begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
        end else begin
            r_settle_cnt <= '0;
        end
    end

    // JSELECT and scan_done are decoded from the next state so they are
    // registered yet aligned with the state they belong to.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_jselect   <= 1'b0;
            r_scan_done <= 1'b0;
        end else begin
            r_jselect   <= (w_next_state == c_SETTLE2) ||
                           (w_next_state == c_SAMPLE2) ||
                           (w_next_state == c_COMMIT);
            r_scan_done <= (w_next_state == c_COMMIT);
        end
    end

    // ------------------------------------------------------------------
    // Raw sample capture (only in the two sample states)
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_raw1 <= '1;
            r_raw2 <= '1;
            r_rawc <= '1;
        end else begin
            if (r_state == c_SAMPLE1) begin
                // Active-low wired-AND: either source pulling low wins.
                r_raw1 <= JJOY & {2'b11, JOYSTICK};
            end
            if (r_state == c_SAMPLE2) begin
                r_raw2 <= JJOY;
                r_rawc <= JCOIN;
            end
        end
    end

    assign w_raw_all = {r_rawc, r_raw2, r_raw1};

    // ------------------------------------------------------------------
    // Per-bit debouncers, updated once per scan in the commit cycle.
    // A counter stays below DEBOUNCE, so 4 bits never wrap.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < c_NBITS; i++) begin : g_db
        logic       r_out;
        logic [3:0] r_cnt;

        always_ff @(posedge pclk) begin
            if (reset) begin
                r_out <= 1'b1;
                r_cnt <= '0;
            end else if (r_state == c_COMMIT) begin
                if (w_raw_all[i] == r_out) begin
                    r_cnt <= '0;
                end else if ((r_cnt + 4'd1) == c_DEBOUNCE) begin
                    r_out <= w_raw_all[i];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end

        assign w_db_out[i] = r_out;
    end

    assign JSELECT   = r_jselect;
    assign scan_done = r_scan_done;
    assign joystick1 = w_db_out[7:0];
    assign joystick2 = w_db_out[15:8];
    assign coin      = w_db_out[17:16];

endmodule
`default_nettype wire
